// File: rtl/apb4_pkg.sv
// Shared register offsets, bit indices and FSM state type for the APB4 stream FIFO completer.
package apb4_pkg;

  localparam logic [7:0] DATA_OFS   = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h04;
  localparam logic [7:0] CTRL_OFS   = 8'h08;
  localparam logic [7:0] THRESH_OFS = 8'h0C;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 16;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb4_sync_fifo.sv
// Synchronous FIFO with push, pop and flush; head reads as 0 while empty.
module apb4_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DW-1:0]            data_i,
  output logic [DW-1:0]            data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Flush dominates both push and pop in the same cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/apb4_stream_fifo_slv.sv
// APB4 completer buffering write data into a FIFO drained by a valid/ready stream.
// THRESH register and IRQ are built only when APB4_STREAM_FIFO_IRQ_EN is defined.
//   state | meaning
//   IDLE  | no transfer in progress, waiting for a setup phase
//   WAIT  | access phase, counting down wait states
//   RESP  | PREADY high for one cycle, write side effects commit
module apb4_stream_fifo_slv
  import apb4_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic                    OUT_VALID,
  output logic [DATA_WIDTH-1:0]   OUT_DATA,
  input  logic                    OUT_READY,
  output logic                    IRQ
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  apb_state_e            state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  ovf_q, ovf_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push, pop, flush, clr_ovf, ovf_set;

  logic [7:0]            ofs;
  logic                  is_data, is_status, is_ctrl, is_thresh;
  logic                  in_resp, err, wr_ok;
  logic [31:0]           status_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_paddr;

  assign unused_paddr = ^PADDR[ADDR_WIDTH-1:8];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (PSEL && !PENABLE) begin
          wcnt_d  = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ofs       = PADDR[7:0];
  assign is_data   = (ofs == DATA_OFS);
  assign is_status = (ofs == STATUS_OFS);
  assign is_ctrl   = (ofs == CTRL_OFS);
`ifdef APB4_STREAM_FIFO_IRQ_EN
  assign is_thresh = (ofs == THRESH_OFS);
`else
  assign is_thresh = 1'b0;
`endif

  // Full/empty here are the pre-cycle values, so a same-cycle stream pop cannot rescue a push.
  always_comb begin
    err = 1'b0;
    if (PADDR[1:0] != 2'b00)                                  err = 1'b1;
    else if (!(is_data || is_status || is_ctrl || is_thresh)) err = 1'b1;
    else if (PWRITE && is_status)                             err = 1'b1;
    else if (!PWRITE && is_ctrl)                              err = 1'b1;
    else if (PWRITE && is_data && (!(&PSTRB) || fifo_full))   err = 1'b1;
    else if (!PWRITE && is_data && fifo_empty)                err = 1'b1;
  end

  assign in_resp = (state_q == RESP);
  assign wr_ok   = in_resp && PWRITE && !err;
  assign push    = wr_ok && is_data;
  assign flush   = wr_ok && is_ctrl && PWDATA[CTRL_FLUSH_BIT];
  assign clr_ovf = wr_ok && is_ctrl && PWDATA[CTRL_CLR_OVF_BIT];
  assign ovf_set = in_resp && PWRITE && is_data && fifo_full;
  assign pop     = !fifo_empty && OUT_READY;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_comb begin
    status_word                          = '0;
    status_word[STAT_EMPTY_BIT]          = fifo_empty;
    status_word[STAT_FULL_BIT]           = fifo_full;
    status_word[STAT_OVF_BIT]            = ovf_q;
    status_word[STAT_CNT_LSB +: CW]      = fifo_count;
  end

`ifdef APB4_STREAM_FIFO_IRQ_EN
  logic [CW-1:0] thresh_q, thresh_d;
  logic          irq_q;

  always_comb begin
    thresh_d = thresh_q;
    if (wr_ok && is_thresh) begin
      for (int i = 0; i < CW; i++) begin
        if (PSTRB[i/8]) thresh_d[i] = PWDATA[i];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= ((fifo_count >= thresh_q) && (thresh_q != '0)) || ovf_q;
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (is_data)        rd_data = fifo_head;
    else if (is_status) rd_data = DATA_WIDTH'(status_word);
`ifdef APB4_STREAM_FIFO_IRQ_EN
    else if (is_thresh) rd_data = DATA_WIDTH'(thresh_q);
`endif
  end

  assign PREADY  = in_resp;
  assign PSLVERR = in_resp && err;
  assign PRDATA  = (in_resp && !PWRITE && !err) ? rd_data : '0;

  apb4_sync_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (PWDATA),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign OUT_VALID = !fifo_empty;
  assign OUT_DATA  = fifo_head;

endmodule

// File: tb/tb_apb4_stream_fifo_slv.sv
// Directed bench for apb4_stream_fifo_slv: vector table plus hand-written corner sequences.
module tb_apb4_stream_fifo_slv;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int WC    = 1;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [DW-1:0] PWDATA = '0;
  logic [3:0]    PSTRB = '0;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;
  logic          OUT_VALID;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_READY = 1'b0;
  logic          IRQ;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vq[$];

  apb4_stream_fifo_slv #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .FIFO_DEPTH  (DEPTH),
    .WAIT_CYCLES (WC)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .OUT_READY (OUT_READY),
    .IRQ       (IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full APB transfer; optionally pulses OUT_READY on the PREADY cycle.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic pop_at_resp,
                     output logic [31:0] rdata, output logic err, output int ncyc);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    ncyc = 2;
    @(negedge PCLK);
    while (!PREADY && ncyc < 40) begin
      @(negedge PCLK);
      ncyc++;
    end
    if (!PREADY) begin
      n_checks++;
      n_errors++;
      $display("FAIL apb_timeout: PREADY still 0 after %0d cycles, required 1", ncyc);
    end
    rdata = PRDATA;
    err   = PSLVERR;
    if (pop_at_resp) OUT_READY = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; OUT_READY = 1'b0;
  endtask

  task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          nc;
    apb(1'b1, addr, wdata, strb, 1'b0, rd, er, nc);
    chk({name, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr,
                        input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          nc;
    apb(1'b0, addr, 32'h0, 4'h0, 1'b0, rd, er, nc);
    chk({name, "_err"}, 32'(er), 32'(exp_err));
    chk({name, "_rdata"}, rd, exp_data);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          nc;
    logic        exp_irq_ovf;

`ifdef APB4_STREAM_FIFO_IRQ_EN
    exp_irq_ovf = 1'b1;
`else
    exp_irq_ovf = 1'b0;
`endif

    // {wr, addr, wdata, strb, exp_err, exp_rdata}; runs with one entry (0xA5A5_0001) queued.
    vq.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h0001_0000});
    vq.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001});
    vq.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0});
    vq.push_back('{1'b0, 32'h02, 32'h0, 4'h0, 1'b1, 32'h0});
    vq.push_back('{1'b1, 32'h00, 32'h1234_5678, 4'h3, 1'b1, 32'h0});
    vq.push_back('{1'b1, 32'h04, 32'h0, 4'hF, 1'b1, 32'h0});
    vq.push_back('{1'b0, 32'h08, 32'h0, 4'h0, 1'b1, 32'h0});
    vq.push_back('{1'b1, 32'h11, 32'h0, 4'hF, 1'b1, 32'h0});
    vq.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h0001_0000});
    vq.push_back('{1'b1, 32'h08, 32'h1, 4'hF, 1'b0, 32'h0});
    vq.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h0000_0001});
    vq.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 1'b1, 32'h0});
`ifdef APB4_STREAM_FIFO_IRQ_EN
    vq.push_back('{1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, 32'h0});
`else
    vq.push_back('{1'b0, 32'h0C, 32'h0, 4'h0, 1'b1, 32'h0});
    vq.push_back('{1'b1, 32'h0C, 32'h4, 4'hF, 1'b1, 32'h0});
`endif

    // Reset values
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", 32'(PREADY), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'h0);
    chk("rst_out_data", OUT_DATA, 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    #2 PRESETn = 1'b1;

    // First write: timing and stream head
    apb(1'b1, 32'h00, 32'hA5A5_0001, 4'hF, 1'b0, rd, er, nc);
    chk("first_wr_cycles", 32'(nc), 32'(2 + WC));
    chk("first_wr_err", 32'(er), 32'h0);
    @(negedge PCLK);
    chk("first_out_valid", 32'(OUT_VALID), 32'h1);
    chk("first_out_data", OUT_DATA, 32'hA5A5_0001);

    foreach (vq[i]) begin
      apb(vq[i].wr, vq[i].addr, vq[i].wdata, vq[i].strb, 1'b0, rd, er, nc);
      chk($sformatf("vec%0d_cycles", i), 32'(nc), 32'(2 + WC));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vq[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), rd, vq[i].exp_rdata);
    end
`ifndef APB4_STREAM_FIFO_IRQ_EN
    chk("noirq_irq_low", 32'(IRQ), 32'h0);
`endif

    // Fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) wr_chk($sformatf("fill%0d", i), 32'h00, 32'h100 + 32'(i), 4'hF, 1'b0);
    wr_chk("overflow_wr", 32'h00, 32'h1FF, 4'hF, 1'b1);
    rd_chk("full_status", 32'h04, 32'h0010_0006, 1'b0);
    chk("full_head", OUT_DATA, 32'h100);
    chk("ovf_irq", 32'(IRQ), 32'(exp_irq_ovf));
    wr_chk("clr_ovf", 32'h08, 32'h2, 4'hF, 1'b0);
    rd_chk("clr_ovf_status", 32'h04, 32'h0010_0002, 1'b0);

    // Push to full FIFO while the stream pops in the same cycle
    apb(1'b1, 32'h00, 32'h200, 4'hF, 1'b1, rd, er, nc);
    chk("full_push_pop_err", 32'(er), 32'h1);
    rd_chk("full_push_pop_status", 32'h04, 32'h000F_0004, 1'b0);
    apb(1'b1, 32'h00, 32'h201, 4'hF, 1'b1, rd, er, nc);
    chk("push_pop_err", 32'(er), 32'h0);
    rd_chk("push_pop_status", 32'h04, 32'h000F_0004, 1'b0);
    chk("push_pop_head", OUT_DATA, 32'h102);
    wr_chk("flush_clr", 32'h08, 32'h3, 4'hF, 1'b0);
    rd_chk("flush_clr_status", 32'h04, 32'h0000_0001, 1'b0);

    // Flush wins over a same-cycle stream pop
    for (int i = 0; i < 3; i++) wr_chk($sformatf("pre_flush%0d", i), 32'h00, 32'h301 + 32'(i), 4'hF, 1'b0);
    chk("pre_flush_head", OUT_DATA, 32'h301);
    apb(1'b1, 32'h08, 32'h1, 4'hF, 1'b1, rd, er, nc);
    chk("flush_pop_err", 32'(er), 32'h0);
    @(negedge PCLK);
    chk("flush_out_valid", 32'(OUT_VALID), 32'h0);
    chk("flush_out_data", OUT_DATA, 32'h0);
    rd_chk("flush_status", 32'h04, 32'h0000_0001, 1'b0);

`ifdef APB4_STREAM_FIFO_IRQ_EN
    wr_chk("thresh_wr", 32'h0C, 32'h4, 4'hF, 1'b0);
    rd_chk("thresh_rd", 32'h0C, 32'h4, 1'b0);
    wr_chk("thresh_nostrb", 32'h0C, 32'h1F, 4'h0, 1'b0);
    rd_chk("thresh_nostrb_rd", 32'h0C, 32'h4, 1'b0);
    for (int i = 0; i < 3; i++) wr_chk($sformatf("irq_push%0d", i), 32'h00, 32'h400 + 32'(i), 4'hF, 1'b0);
    @(posedge PCLK); #1;
    chk("irq_below_thresh", 32'(IRQ), 32'h0);
    wr_chk("irq_push3", 32'h00, 32'h403, 4'hF, 1'b0);
    @(posedge PCLK); #1;
    chk("irq_at_thresh", 32'(IRQ), 32'h1);
    @(negedge PCLK);
    OUT_READY = 1'b1;
    @(posedge PCLK); #1;
    OUT_READY = 1'b0;
    @(posedge PCLK); #1;
    chk("irq_after_pop", 32'(IRQ), 32'h0);
`endif

    // Abort: PSEL drops during the wait state
    wr_chk("pre_abort_flush", 32'h08, 32'h1, 4'hF, 1'b0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hDEAD; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    @(negedge PCLK);
    chk("abort_pready_a", 32'(PREADY), 32'h0);
    @(negedge PCLK);
    chk("abort_pready_b", 32'(PREADY), 32'h0);
    rd_chk("abort_status", 32'h04, 32'h0000_0001, 1'b0);

    // Reset in the middle of a transfer
    wr_chk("pre_rst_push", 32'h00, 32'h55, 4'hF, 1'b0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h66; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(OUT_VALID), 32'h0);
    chk("midrst_pready", 32'(PREADY), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    rd_chk("midrst_status", 32'h04, 32'h0000_0001, 1'b0);
    chk("midrst_irq", 32'(IRQ), 32'h0);
`ifdef APB4_STREAM_FIFO_IRQ_EN
    rd_chk("midrst_thresh", 32'h0C, 32'h0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required to have finished", $time);
    $fatal(1);
  end

endmodule
